// File: rtl/in_bank_pkg.sv
// Shared types and constants for the byte-to-bank word assembler.
package in_bank_pkg;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_COLLECT = 1'b1
    } state_e;

    typedef enum logic {
        TGT_BANK00 = 1'b0,
        TGT_BANK01 = 1'b1
    } target_e;

    localparam logic [1:0] PROJ_BANK00  = 2'b00;
    localparam logic [1:0] PROJ_BANK01  = 2'b10;
    localparam int         BANK00_BYTES = 4;
    localparam int         BANK01_BYTES = 2;
    localparam int         TIMER_W      = 16;

    function automatic logic proj_valid(input logic [1:0] sel);
        return (sel == PROJ_BANK00) || (sel == PROJ_BANK01);
    endfunction

    // Index of the byte that completes a word for the given target.
    function automatic logic [1:0] last_byte_idx(input target_e tgt);
        logic [1:0] idx;
        case (tgt)
            TGT_BANK00: idx = 2'(BANK00_BYTES - 1);
            TGT_BANK01: idx = 2'(BANK01_BYTES - 1);
            default:    idx = 2'(BANK00_BYTES - 1);
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/in_bank_assembler_idle_timer.sv
// Mid-word idle counter: clear wins over enable; expire flags the cycle the
// count would reach TIMEOUT_CYCLES.
module in_bank_assembler_idle_timer
    import in_bank_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam logic [TIMER_W-1:0] LIMIT_M1 = TIMER_W'(TIMEOUT_CYCLES - 1);

    logic [TIMER_W-1:0] count_q;
    logic [TIMER_W-1:0] count_d;

    // Next count and expiry detection.
    always_comb begin
        count_d = count_q;
        expire  = 1'b0;
        if (clear) begin
            count_d = {TIMER_W{1'b0}};
        end else if (enable) begin
            if (count_q == LIMIT_M1) begin
                expire  = 1'b1;
                count_d = {TIMER_W{1'b0}};
            end else begin
                count_d = count_q + {{(TIMER_W-1){1'b0}}, 1'b1};
            end
        end else begin
            count_d = count_q;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= {TIMER_W{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/in_bank_assembler.sv
// Assembles little-endian byte streams into Bank00 (32-bit) / Bank01 (10-bit)
// words. Optional Bank01 format check enabled by macro IN_BANK_FORMAT_CHECK_EN.
module in_bank_assembler
    import in_bank_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        write_enable,
    input  logic [7:0]  data_in,
    input  logic [1:0]  proj_sel,
    input  logic        flush,
    output logic [31:0] bank00_data,
    output logic        bank00_we,
    output logic [9:0]  bank01_data,
    output logic        bank01_we,
    output logic        busy,
    output logic [1:0]  byte_cnt,
    output logic        timeout_err,
    output logic        fmt_err
);

    state_e      state_q,       state_d;
    target_e     target_q,      target_d;
    logic [1:0]  byte_cnt_q,    byte_cnt_d;
    logic [23:0] lanes_q,       lanes_d;
    logic [31:0] bank00_data_q, bank00_data_d;
    logic [9:0]  bank01_data_q, bank01_data_d;
    logic        bank00_we_q,   bank00_we_d;
    logic        bank01_we_q,   bank01_we_d;
    logic        timeout_err_q, timeout_err_d;
`ifdef IN_BANK_FORMAT_CHECK_EN
    logic        fmt_err_q,     fmt_err_d;
`endif

    logic accept_s;
    logic timer_clear_s;
    logic timer_enable_s;
    logic timer_expire_s;

    // A byte is taken unless flushed; from IDLE only with a valid target.
    assign accept_s = write_enable && !flush &&
                      ((state_q == ST_COLLECT) || proj_valid(proj_sel));

    assign timer_clear_s  = accept_s || flush || (state_q == ST_IDLE);
    assign timer_enable_s = (state_q == ST_COLLECT) && !write_enable;

    in_bank_assembler_idle_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_idle_timer (
        .clk   (clk),
        .rst   (rst),
        .clear (timer_clear_s),
        .enable(timer_enable_s),
        .expire(timer_expire_s)
    );

    // Next-state, lane capture and commit decisions.
    always_comb begin
        state_d       = state_q;
        target_d      = target_q;
        byte_cnt_d    = byte_cnt_q;
        lanes_d       = lanes_q;
        bank00_data_d = bank00_data_q;
        bank01_data_d = bank01_data_q;
        bank00_we_d   = 1'b0;
        bank01_we_d   = 1'b0;
        timeout_err_d = 1'b0;
`ifdef IN_BANK_FORMAT_CHECK_EN
        fmt_err_d     = fmt_err_q;
`endif
        if (flush) begin
            state_d    = ST_IDLE;
            byte_cnt_d = 2'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept_s) begin
                        target_d      = (proj_sel == PROJ_BANK01) ? TGT_BANK01 : TGT_BANK00;
                        lanes_d[7:0]  = data_in;
                        byte_cnt_d    = 2'd1;
                        state_d       = ST_COLLECT;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_COLLECT: begin
                    if (write_enable) begin
                        if (byte_cnt_q == last_byte_idx(target_q)) begin
                            state_d    = ST_IDLE;
                            byte_cnt_d = 2'd0;
                            if (target_q == TGT_BANK00) begin
                                bank00_data_d = {data_in, lanes_q};
                                bank00_we_d   = 1'b1;
                            end else begin
`ifdef IN_BANK_FORMAT_CHECK_EN
                                if (data_in[7:2] != 6'd0) begin
                                    fmt_err_d = 1'b1;
                                end else begin
                                    bank01_data_d = {data_in[1:0], lanes_q[7:0]};
                                    bank01_we_d   = 1'b1;
                                end
`else
                                bank01_data_d = {data_in[1:0], lanes_q[7:0]};
                                bank01_we_d   = 1'b1;
`endif
                            end
                        end else begin
                            case (byte_cnt_q)
                                2'd1:    lanes_d[15:8]  = data_in;
                                2'd2:    lanes_d[23:16] = data_in;
                                default: lanes_d        = lanes_q;
                            endcase
                            byte_cnt_d = byte_cnt_q + 2'd1;
                        end
                    end else if (timer_expire_s) begin
                        state_d       = ST_IDLE;
                        byte_cnt_d    = 2'd0;
                        timeout_err_d = 1'b1;
                    end else begin
                        state_d = ST_COLLECT;
                    end
                end
                default: begin
                    state_d    = ST_IDLE;
                    byte_cnt_d = 2'd0;
                end
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            target_q      <= TGT_BANK00;
            byte_cnt_q    <= 2'd0;
            lanes_q       <= 24'd0;
            bank00_data_q <= 32'd0;
            bank01_data_q <= 10'd0;
            bank00_we_q   <= 1'b0;
            bank01_we_q   <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            target_q      <= target_d;
            byte_cnt_q    <= byte_cnt_d;
            lanes_q       <= lanes_d;
            bank00_data_q <= bank00_data_d;
            bank01_data_q <= bank01_data_d;
            bank00_we_q   <= bank00_we_d;
            bank01_we_q   <= bank01_we_d;
            timeout_err_q <= timeout_err_d;
        end
    end

`ifdef IN_BANK_FORMAT_CHECK_EN
    // Sticky format error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            fmt_err_q <= 1'b0;
        end else begin
            fmt_err_q <= fmt_err_d;
        end
    end

    assign fmt_err = fmt_err_q;
`else
    assign fmt_err = 1'b0;
`endif

    assign bank00_data = bank00_data_q;
    assign bank00_we   = bank00_we_q;
    assign bank01_data = bank01_data_q;
    assign bank01_we   = bank01_we_q;
    assign busy        = (state_q == ST_COLLECT);
    assign byte_cnt    = byte_cnt_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_in_bank_assembler.sv
// Directed plus random bench for in_bank_assembler against a queue-based
// reference model; follows IN_BANK_FORMAT_CHECK_EN if defined.
module tb_in_bank_assembler;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        write_enable = 1'b0;
    logic [7:0]  data_in = 8'd0;
    logic [1:0]  proj_sel = 2'd0;
    logic        flush = 1'b0;
    logic [31:0] bank00_data;
    logic        bank00_we;
    logic [9:0]  bank01_data;
    logic        bank01_we;
    logic        busy;
    logic [1:0]  byte_cnt;
    logic        timeout_err;
    logic        fmt_err;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: pending bytes of the word in progress plus committed state.
    logic [7:0]  m_part[$];
    logic        m_t1;
    int          m_idle;
    logic [31:0] m_b0;
    logic [9:0]  m_b1;
    logic        m_b0we, m_b1we, m_terr, m_ferr;

    in_bank_assembler #(.TIMEOUT_CYCLES(TO)) dut (
        .clk         (clk),
        .rst         (rst),
        .write_enable(write_enable),
        .data_in     (data_in),
        .proj_sel    (proj_sel),
        .flush       (flush),
        .bank00_data (bank00_data),
        .bank00_we   (bank00_we),
        .bank01_data (bank01_data),
        .bank01_we   (bank01_we),
        .busy        (busy),
        .byte_cnt    (byte_cnt),
        .timeout_err (timeout_err),
        .fmt_err     (fmt_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model(input logic we, input logic [7:0] d, input logic [1:0] sel,
                         input logic fl, input logic r);
        int need;
        m_b0we = 1'b0;
        m_b1we = 1'b0;
        m_terr = 1'b0;
        if (r) begin
            m_part.delete();
            m_idle = 0;
            m_b0   = 32'd0;
            m_b1   = 10'd0;
            m_ferr = 1'b0;
        end else if (fl) begin
            m_part.delete();
            m_idle = 0;
        end else if (m_part.size() == 0) begin
            if (we && (sel == 2'b00 || sel == 2'b10)) begin
                m_part.push_back(d);
                m_t1   = (sel == 2'b10);
                m_idle = 0;
            end
        end else if (we) begin
            m_part.push_back(d);
            m_idle = 0;
            need = m_t1 ? 2 : 4;
            if (m_part.size() == need) begin
                if (!m_t1) begin
                    m_b0   = {m_part[3], m_part[2], m_part[1], m_part[0]};
                    m_b0we = 1'b1;
                end else begin
`ifdef IN_BANK_FORMAT_CHECK_EN
                    if ((m_part[1] >> 2) != 8'd0) begin
                        m_ferr = 1'b1;
                    end else begin
                        m_b1   = {m_part[1][1:0], m_part[0]};
                        m_b1we = 1'b1;
                    end
`else
                    m_b1   = {m_part[1][1:0], m_part[0]};
                    m_b1we = 1'b1;
`endif
                end
                m_part.delete();
            end
        end else begin
            m_idle++;
            if (m_idle >= TO) begin
                m_part.delete();
                m_idle = 0;
                m_terr = 1'b1;
            end
        end
    endtask

    task automatic step(input logic we, input logic [7:0] d, input logic [1:0] sel,
                        input logic fl, input logic r);
        write_enable = we;
        data_in      = d;
        proj_sel     = sel;
        flush        = fl;
        rst          = r;
        @(posedge clk);
        model(we, d, sel, fl, r);
        #1;
        chk("bank00_data", bank00_data, m_b0);
        chk("bank00_we",   32'(bank00_we), 32'(m_b0we));
        chk("bank01_data", 32'(bank01_data), 32'(m_b1));
        chk("bank01_we",   32'(bank01_we), 32'(m_b1we));
        chk("busy",        32'(busy), 32'(m_part.size() != 0));
        chk("byte_cnt",    32'(byte_cnt), 32'(m_part.size()));
        chk("timeout_err", 32'(timeout_err), 32'(m_terr));
        chk("fmt_err",     32'(fmt_err), 32'(m_ferr));
    endtask

    task automatic byte_in(input logic [7:0] d, input logic [1:0] sel);
        step(1'b1, d, sel, 1'b0, 1'b0);
    endtask

    task automatic idle_cyc();
        step(1'b0, 8'h00, 2'b00, 1'b0, 1'b0);
    endtask

    initial begin
        m_t1 = 1'b0; m_idle = 0; m_b0 = 32'd0; m_b1 = 10'd0; m_ferr = 1'b0;
        m_b0we = 1'b0; m_b1we = 1'b0; m_terr = 1'b0;

        // Reset, with a byte offered to show rst overrides inputs.
        step(1'b1, 8'h5A, 2'b00, 1'b0, 1'b1);
        step(1'b0, 8'h00, 2'b00, 1'b0, 1'b1);
        chk("rst_bank00_data", bank00_data, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);

        // Bank00 word at full rate.
        byte_in(8'h11, 2'b00); byte_in(8'h22, 2'b00);
        byte_in(8'h33, 2'b00); byte_in(8'h44, 2'b00);
        chk("b00_we", 32'(bank00_we), 32'd1);
        chk("b00_word", bank00_data, 32'h44332211);
        idle_cyc();
        chk("b00_we_one_cycle", 32'(bank00_we), 32'd0);

        // Bank01 word; proj_sel ignored on byte 2.
        byte_in(8'hA5, 2'b10); byte_in(8'h03, 2'b00);
        chk("b01_we", 32'(bank01_we), 32'd1);
        chk("b01_word", 32'(bank01_data), 32'h3A5);

        // Timeout after two bytes and TO idle cycles.
        byte_in(8'h55, 2'b00); byte_in(8'h66, 2'b00);
        repeat (TO) idle_cyc();
        chk("to_pulse", 32'(timeout_err), 32'd1);
        chk("to_busy", 32'(busy), 32'd0);
        chk("to_data_kept", bank00_data, 32'h44332211);
        idle_cyc();
        chk("to_pulse_one_cycle", 32'(timeout_err), 32'd0);

        // Byte on the would-expire cycle is accepted.
        byte_in(8'h77, 2'b00); byte_in(8'h88, 2'b00);
        repeat (TO - 1) idle_cyc();
        byte_in(8'h99, 2'b11);
        chk("late_no_to", 32'(timeout_err), 32'd0);
        chk("late_cnt", 32'(byte_cnt), 32'd3);
        step(1'b0, 8'h00, 2'b00, 1'b1, 1'b0);

        // Flush beats a simultaneous byte; next word is clean.
        byte_in(8'hE1, 2'b00); byte_in(8'hE2, 2'b00); byte_in(8'hE3, 2'b00);
        step(1'b1, 8'hE4, 2'b00, 1'b1, 1'b0);
        chk("flush_no_we", 32'(bank00_we), 32'd0);
        chk("flush_cnt", 32'(byte_cnt), 32'd0);
        byte_in(8'h01, 2'b00); byte_in(8'h02, 2'b00);
        byte_in(8'h03, 2'b00); byte_in(8'h04, 2'b00);
        chk("post_flush_word", bank00_data, 32'h04030201);

        // Bank01 with upper bits set in byte 1.
        byte_in(8'h10, 2'b10); byte_in(8'h07, 2'b10);
`ifdef IN_BANK_FORMAT_CHECK_EN
        chk("fmt_err_set", 32'(fmt_err), 32'd1);
        chk("fmt_no_we", 32'(bank01_we), 32'd0);
        chk("fmt_data_kept", 32'(bank01_data), 32'h3A5);
`else
        chk("fmt_we", 32'(bank01_we), 32'd1);
        chk("fmt_ignored_word", 32'(bank01_data), 32'h310);
`endif

        // Invalid target dropped in IDLE.
        byte_in(8'hC3, 2'b01);
        chk("invalid_sel_idle", 32'(busy), 32'd0);

        // Reset mid-word, then a clean word.
        byte_in(8'hF0, 2'b00); byte_in(8'hF1, 2'b00);
        step(1'b1, 8'hF2, 2'b00, 1'b0, 1'b1);
        chk("midrst_data", bank00_data, 32'd0);
        chk("midrst_cnt", 32'(byte_cnt), 32'd0);
        byte_in(8'hAA, 2'b00); byte_in(8'hBB, 2'b00);
        byte_in(8'hCC, 2'b00); byte_in(8'hDD, 2'b00);
        chk("midrst_word", bank00_data, 32'hDDCCBBAA);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            logic        we, fl, r;
            logic [7:0]  d;
            logic [1:0]  sel;
            we  = ($urandom_range(0, 9) < 6);
            d   = 8'($urandom);
            if ($urandom_range(0, 3) == 0) d[7:2] = 6'd0;
            sel = 2'($urandom);
            fl  = ($urandom_range(0, 24) == 0);
            r   = ($urandom_range(0, 99) == 0);
            step(we, d, sel, fl, r);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
